regfile_ctx_seq: RTL and testbench

Context save/restore sequencer for the 8x16 general-purpose register file. On command it walks R0..R7 in a single pass. A save reads each register through the SR1 read port and writes it to memory. A restore reads each word from memory and loads it through the DR/LD_REG write port. It sits beside the main control FSM and takes ownership of the register-file ports while busy; the trap/interrupt entry and the debug monitor use it.

---
 rtl/lc3_pkg.sv | 39 +++
 rtl/regfile_ctx_seq_mem_xfer_hs.sv | 69 ++++++
 rtl/regfile_ctx_seq.sv | 203 ++++++++++++++++++++
 tb/tb_regfile_ctx_seq.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 register-file context sequencer.
//   NREG, DATA_W, ADDR_W : register count, data width, memory address width
//   ctx_state_e          : sequencer state encoding
//   addr_add_wrap()      : base + register index, wrapping modulo 2**ADDR_W
package lc3_pkg;

    localparam int NREG   = 8;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int IDX_W  = $clog2(NREG);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SCAN    = 3'd1;
    localparam logic [2:0] ST_SAVE_RD = 3'd2;
    localparam logic [2:0] ST_SAVE_WR = 3'd3;
    localparam logic [2:0] ST_RST_RD  = 3'd4;
    localparam logic [2:0] ST_RST_WR  = 3'd5;
    localparam logic [2:0] ST_FIN     = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_SCAN    = ST_SCAN,
        S_SAVE_RD = ST_SAVE_RD,
        S_SAVE_WR = ST_SAVE_WR,
        S_RST_RD  = ST_RST_RD,
        S_RST_WR  = ST_RST_WR,
        S_FIN     = ST_FIN
    } ctx_state_e;

    // Slot address of register idx; the carry out of the top bit is dropped,
    // so a save area may straddle the top of memory (0xFFFE + 3 = 0x0001).
    function automatic logic [ADDR_W-1:0] addr_add_wrap(
        input logic [ADDR_W-1:0] base,
        input logic [IDX_W-1:0]  idx
    );
        return base + {{(ADDR_W-IDX_W){1'b0}}, idx};
    endfunction

endpackage

// File: rtl/regfile_ctx_seq_mem_xfer_hs.sv
// mem_xfer_hs: single-transfer memory handshake holder.
// A launch pulse loads direction, address and (for writes) data and raises
// mem_req; everything is held until mem_ready, then mem_req drops on the
// following edge. Read data is captured in the completing cycle.
//   launch_i/we_i/addr_i/wdata_i : start one transfer
//   mem_*_o, mem_ready_i, mem_rdata_i : memory-side handshake
//   xfer_done_o : combinational, high in the cycle the transfer completes
//   rdata_o     : last captured read data
module mem_xfer_hs
    import lc3_pkg::*;
(
    input  logic              clk,
    input  logic              reset_,
    input  logic              launch_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              mem_ready_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              xfer_done_o,
    output logic [DATA_W-1:0] rdata_o
);

    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    assign xfer_done_o = req_q & mem_ready_i;

    // NOTE: every register here, data included, is reset so that all outputs
    // read 0 while reset_ is low; sequential state uses <= only, so each
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (launch_i) begin
                req_q  <= 1'b1;
                we_q   <= we_i;
                addr_q <= addr_i;
                if (we_i) begin
                    wdata_q <= wdata_i;
                end
            end else if (xfer_done_o) begin
                req_q <= 1'b0;
                if (!we_q) begin
                    rdata_q <= mem_rdata_i;
                end
            end
        end
    end

    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign rdata_o     = rdata_q;

endmodule

// File: rtl/regfile_ctx_seq.sv
// regfile_ctx_seq: context save/restore sequencer for the 8x16 register file.
// Walks R0..R7 once per command. Save reads each selected register on SR1 and
// writes it to base+idx; restore reads base+idx and loads it through DR/LD_REG.
//   start_save/start_restore/base_addr/reg_mask/abort : command interface
//   busy/done/aborted : status (busy = register-file port ownership)
//   rf_sr1_sel/rf_sr1/rf_dr/rf_ld_reg/rf_wdata        : register-file ports
//   mem_req/mem_we/mem_addr/mem_wdata/mem_ready/mem_rdata : memory handshake
module regfile_ctx_seq
    import lc3_pkg::*;
(
    input  logic              clk,
    input  logic              reset_,
    input  logic              start_save,
    input  logic              start_restore,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [NREG-1:0]   reg_mask,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [IDX_W-1:0]  rf_sr1_sel,
    input  logic [DATA_W-1:0] rf_sr1,
    output logic [IDX_W-1:0]  rf_dr,
    output logic              rf_ld_reg,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    ctx_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [NREG-1:0]   mask_q;
    logic [ADDR_W-1:0] base_q;
    logic              save_q;
    logic              abort_pend_q;
    logic              aborted_q;
    logic              busy_q;
    logic              done_q;
    logic [IDX_W-1:0]  rf_sr1_sel_q;
    logic [IDX_W-1:0]  rf_dr_q;
    logic              rf_ld_reg_q;

    logic start;
    logic abort_seen;
    logic last_idx;
    logic launch;
    logic launch_we;
    logic xfer_done;
    logic [DATA_W-1:0] xfer_rdata;

    assign start      = start_save | start_restore;
    // An abort raised while a transfer is outstanding is remembered until the
    // sequence reaches a point where it may stop.
    assign abort_seen = abort | abort_pend_q;
    assign last_idx   = (idx_q == IDX_W'(NREG - 1));

    mem_xfer_hs u_xfer (
        .clk         (clk),
        .reset_      (reset_),
        .launch_i    (launch),
        .we_i        (launch_we),
        .addr_i      (addr_add_wrap(base_q, idx_q)),
        .wdata_i     (rf_sr1),
        .mem_ready_i (mem_ready),
        .mem_rdata_i (mem_rdata),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .xfer_done_o (xfer_done),
        .rdata_o     (xfer_rdata)
    );

    // NOTE: every signal assigned below gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        launch    = 1'b0;
        launch_we = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SCAN;
                    idx_d   = '0;
                end
            end
            S_SCAN: begin
                if (abort_seen) begin
                    state_d = S_FIN;
                end else if (mask_q[idx_q]) begin
                    if (save_q) begin
                        state_d = S_SAVE_RD;
                    end else begin
                        state_d = S_RST_RD;
                        launch  = 1'b1;
                    end
                end else if (last_idx) begin
                    state_d = S_FIN;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_SAVE_RD: begin
                // rf_sr1 is valid this cycle; the launch registers it as write data.
                if (abort_seen) begin
                    state_d = S_FIN;
                end else begin
                    state_d   = S_SAVE_WR;
                    launch    = 1'b1;
                    launch_we = 1'b1;
                end
            end
            S_SAVE_WR: begin
                if (xfer_done) begin
                    if (abort_seen || last_idx) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_SCAN;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
            end
            S_RST_RD: begin
                // The load always follows a completed read, even under abort.
                if (xfer_done) begin
                    state_d = S_RST_WR;
                end
            end
            S_RST_WR: begin
                if (abort_seen || last_idx) begin
                    state_d = S_FIN;
                end else begin
                    state_d = S_SCAN;
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            mask_q       <= '0;
            base_q       <= '0;
            save_q       <= 1'b0;
            abort_pend_q <= 1'b0;
            aborted_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rf_sr1_sel_q <= '0;
            rf_dr_q      <= '0;
            rf_ld_reg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;

            if (state_q == S_IDLE && start) begin
                base_q       <= base_addr;
                mask_q       <= reg_mask;
                save_q       <= start_save;   // save wins when both are pulsed
                abort_pend_q <= 1'b0;
                aborted_q    <= 1'b0;
            end else if (busy_q) begin
                // busy_q is high exactly when state_q is a working state.
                if (abort) begin
                    abort_pend_q <= 1'b1;
                end
                if (state_d == S_FIN && abort_seen) begin
                    aborted_q <= 1'b1;
                end
            end

            // Status and register-file controls are registered from the next state.
            busy_q      <= (state_d != S_IDLE) && (state_d != S_FIN);
            done_q      <= (state_d == S_FIN);
            rf_ld_reg_q <= (state_q == S_RST_RD) && (state_d == S_RST_WR);

            if (state_q == S_RST_RD && state_d == S_RST_WR) begin
                rf_dr_q <= idx_q;
            end
            if (state_q == S_SCAN && state_d == S_SAVE_RD) begin
                rf_sr1_sel_q <= idx_q;
            end
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign rf_sr1_sel = rf_sr1_sel_q;
    assign rf_dr      = rf_dr_q;
    assign rf_ld_reg  = rf_ld_reg_q;
    assign rf_wdata   = xfer_rdata;

endmodule

// File: tb/tb_regfile_ctx_seq.sv
// Self-checking bench for regfile_ctx_seq. The bench owns a register-file
// array and a 64K-word memory with programmable per-transfer ready delays;
// expected results come from walking the mask in plain loops.
module tb_regfile_ctx_seq;

    logic        clk = 1'b0;
    logic        reset_;
    logic        start_save, start_restore, abort;
    logic [15:0] base_addr;
    logic [7:0]  reg_mask;
    logic        busy, done, aborted;
    logic [2:0]  rf_sr1_sel, rf_dr;
    logic [15:0] rf_sr1, rf_wdata;
    logic        rf_ld_reg;
    logic        mem_req, mem_we, mem_ready;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    regfile_ctx_seq dut (
        .clk           (clk),
        .reset_        (reset_),
        .start_save    (start_save),
        .start_restore (start_restore),
        .base_addr     (base_addr),
        .reg_mask      (reg_mask),
        .abort         (abort),
        .busy          (busy),
        .done          (done),
        .aborted       (aborted),
        .rf_sr1_sel    (rf_sr1_sel),
        .rf_sr1        (rf_sr1),
        .rf_dr         (rf_dr),
        .rf_ld_reg     (rf_ld_reg),
        .rf_wdata      (rf_wdata),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata)
    );

    // Environment: register file and memory
    logic [15:0] rf [8];
    logic [15:0] mem [0:65535];
    assign rf_sr1 = rf[rf_sr1_sel];

    int          n_checks = 0;
    int          n_errors = 0;
    int          waits [8];
    int          xk, wcnt, ld_cnt;
    logic [15:0] h_addr, h_wdata;
    logic        h_we;
    logic [15:0] wr_addr_q [$];
    logic [15:0] wr_data_q [$];
    logic [15:0] rd_addr_q [$];
    logic [15:0] rf_snap [8];
    logic [15:0] mem_snap [8];
    int          done_cyc, busy_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Memory responder and register-file write, evaluated mid-cycle.
    task automatic env_step();
        int w;
        if (rf_ld_reg) begin
            rf[rf_dr] = rf_wdata;
            ld_cnt++;
        end
        mem_rdata = 16'($urandom);
        if (mem_req) begin
            if (wcnt == 0) begin
                h_addr = mem_addr; h_we = mem_we; h_wdata = mem_wdata;
            end else begin
                check("hold_addr", mem_addr, h_addr);
                check("hold_we", mem_we, h_we);
                if (h_we) check("hold_wdata", mem_wdata, h_wdata);
            end
            w = (xk < 8) ? waits[xk] : 0;
            if (wcnt >= w) begin
                mem_ready = 1'b1;
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                    wr_addr_q.push_back(mem_addr);
                    wr_data_q.push_back(mem_wdata);
                end else begin
                    mem_rdata = mem[mem_addr];
                    rd_addr_q.push_back(mem_addr);
                end
                xk++;
                wcnt = 0;
            end else begin
                mem_ready = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ready = 1'b0;
            wcnt = 0;
        end
    endtask

    // One clock: environment at the falling edge, then step to 1ns past the rise.
    task automatic tick();
        @(negedge clk);
        env_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_waits();
        for (int i = 0; i < 8; i++) waits[i] = 0;
    endtask

    // Issue one command and follow it to done (bounded).
    task automatic run(input string nm, input bit sv, input bit both,
                       input logic [15:0] base, input logic [7:0] mask,
                       input int abort_cyc, input int abort_rd, input int restart_cyc);
        bit fired;
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
        ld_cnt = 0; xk = 0; wcnt = 0; fired = 0;
        for (int i = 0; i < 8; i++) begin
            rf_snap[i]  = rf[i];
            mem_snap[i] = mem[base + 16'(i)];
        end
        base_addr = base; reg_mask = mask;
        start_save = sv | both; start_restore = !sv | both;
        tick();
        start_save = 0; start_restore = 0;
        base_addr = 16'($urandom); reg_mask = 8'($urandom);
        done_cyc = -1; busy_cnt = 0;
        for (int c = 1; c <= 600; c++) begin
            if (done) begin
                done_cyc = c;
                check({nm, "_busy_at_done"}, busy, 0);
                break;
            end
            if (busy) busy_cnt++;
            abort = (c == abort_cyc) ||
                    (abort_rd >= 0 && !fired && mem_req && !mem_we && mem_addr == 16'(abort_rd));
            if (abort) fired = 1;
            start_restore = (c == restart_cyc);
            tick();
        end
        abort = 0; start_restore = 0;
        if (done_cyc < 0) check({nm, "_timeout"}, 1, 0);
        tick();
        check({nm, "_done_pulse"}, done, 0);
        check({nm, "_idle_after"}, busy, 0);
    endtask

    // Expected outcome of an unaborted command, derived from the mask walk.
    task automatic verify(input string nm, input bit sv, input logic [15:0] base, input logic [7:0] mask);
        int k = 0, exp_busy = 0, wi = 0, ri = 0;
        int npop = $countones(mask);
        logic [15:0] a, e;
        check({nm, "_n_wr"}, wr_addr_q.size(), sv ? npop : 0);
        check({nm, "_n_rd"}, rd_addr_q.size(), sv ? 0 : npop);
        check({nm, "_n_ld"}, ld_cnt, sv ? 0 : npop);
        for (int i = 0; i < 8; i++) begin
            a = base + 16'(i);
            if (mask[i]) begin
                exp_busy += 3 + waits[k];
                k++;
                if (sv) begin
                    if (wi < wr_addr_q.size()) begin
                        check($sformatf("%s_wr_addr%0d", nm, i), wr_addr_q[wi], a);
                        check($sformatf("%s_wr_data%0d", nm, i), wr_data_q[wi], rf_snap[i]);
                    end
                    wi++;
                end else begin
                    if (ri < rd_addr_q.size())
                        check($sformatf("%s_rd_addr%0d", nm, i), rd_addr_q[ri], a);
                    ri++;
                end
            end else begin
                exp_busy += 1;
            end
            e = (!sv && mask[i]) ? mem_snap[i] : rf_snap[i];
            check($sformatf("%s_rf%0d", nm, i), rf[i], e);
            e = (sv && mask[i]) ? rf_snap[i] : mem_snap[i];
            check($sformatf("%s_slot%0d", nm, i), mem[a], e);
        end
        check({nm, "_done_cyc"}, done_cyc, exp_busy + 1);
        check({nm, "_busy_cyc"}, busy_cnt, exp_busy);
        check({nm, "_aborted"}, aborted, 0);
    endtask

    initial begin
        bit          sv;
        logic [15:0] b;
        logic [7:0]  m;
        reset_ = 0; start_save = 0; start_restore = 0; abort = 0;
        base_addr = 0; reg_mask = 0; mem_ready = 0; mem_rdata = 0;
        xk = 0; wcnt = 0; ld_cnt = 0;
        clear_waits();
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);

        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_aborted", aborted, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_ld", rf_ld_reg, 0);
        check("rst_addr", mem_addr, 0);
        reset_ = 1;
        tick();

        // Full save, zero wait states
        for (int i = 0; i < 8; i++) rf[i] = 16'h1110 + 16'(i);
        run("save_full", 1, 0, 16'h3000, 8'hFF, -1, -1, -1);
        verify("save_full", 1, 16'h3000, 8'hFF);
        check("save_full_cyc25", done_cyc, 25);
        check("save_full_slot7", mem[16'h3007], 16'h1117);

        // Sparse restore
        mem[16'h4000] = 16'hAAAA; mem[16'h4005] = 16'h5555; mem[16'h4007] = 16'h7777;
        for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
        run("rst_a1", 0, 0, 16'h4000, 8'hA1, -1, -1, -1);
        verify("rst_a1", 0, 16'h4000, 8'hA1);
        check("rst_a1_r0", rf[0], 16'hAAAA);
        check("rst_a1_r5", rf[5], 16'h5555);
        check("rst_a1_r7", rf[7], 16'h7777);
        check("rst_a1_reads", rd_addr_q.size(), 3);

        // Address wrap
        run("save_wrap", 1, 0, 16'hFFFE, 8'hFF, -1, -1, -1);
        verify("save_wrap", 1, 16'hFFFE, 8'hFF);
        if (wr_addr_q.size() == 8) begin
            check("wrap_a1", wr_addr_q[1], 16'hFFFF);
            check("wrap_a2", wr_addr_q[2], 16'h0000);
            check("wrap_a7", wr_addr_q[7], 16'h0005);
        end

        // R2 write stalled 4 cycles
        waits[2] = 4;
        run("save_stall", 1, 0, 16'h3100, 8'hFF, -1, -1, -1);
        verify("save_stall", 1, 16'h3100, 8'hFF);
        check("save_stall_busy28", busy_cnt, 28);
        clear_waits();

        // Restore aborted during the (2-cycle delayed) R3 read:
        // R0..R2 take 3 cycles each, R3 takes SCAN + 3 RST_RD + RST_WR = 5.
        waits[3] = 2;
        for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
        run("rst_abort", 0, 0, 16'h5000, 8'hFF, -1, 16'h5003, -1);
        check("rst_abort_aborted", aborted, 1);
        check("rst_abort_reads", rd_addr_q.size(), 4);
        check("rst_abort_loads", ld_cnt, 4);
        check("rst_abort_busy", busy_cnt, 14);
        check("rst_abort_done", done_cyc, 15);
        for (int i = 0; i < 8; i++)
            check($sformatf("rst_abort_rf%0d", i), rf[i], (i < 4) ? mem_snap[i] : rf_snap[i]);
        clear_waits();

        // Abort in the first SCAN cycle: nothing transferred
        run("save_abort0", 1, 0, 16'h6000, 8'hFF, 1, -1, -1);
        check("save_abort0_aborted", aborted, 1);
        check("save_abort0_wr", wr_addr_q.size(), 0);
        check("save_abort0_done", done_cyc, 2);
        check("save_abort0_slot0", mem[16'h6000], mem_snap[0]);

        // Empty mask: 8 SCAN cycles; also clears the sticky aborted flag
        run("mask0", 1, 0, 16'h7000, 8'h00, -1, -1, -1);
        verify("mask0", 1, 16'h7000, 8'h00);

        // Reset in the middle of a stalled save write
        for (int i = 0; i < 8; i++) rf[i] = 16'h2220 + 16'(i);
        waits[2] = 10;
        xk = 0;
        base_addr = 16'h3300; reg_mask = 8'hFF; start_save = 1;
        tick();
        start_save = 0;
        for (int i = 0; i < 10; i++) tick();
        check("mid_req_before_reset", mem_req, 1);
        reset_ = 0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_req", mem_req, 0);
        check("mid_rst_we", mem_we, 0);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_wdata", mem_wdata, 0);
        check("mid_rst_sel", rf_sr1_sel, 0);
        tick();
        reset_ = 1;
        clear_waits();
        tick();
        run("both_start", 1, 1, 16'h3400, 8'hFF, -1, -1, 5);
        verify("both_start", 1, 16'h3400, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_both_idle", busy | mem_req, 0);
        end

        // Randomized commands
        for (int t = 0; t < 16; t++) begin
            sv = 1'($urandom_range(0, 1));
            b  = (t % 4 == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7)) : 16'($urandom);
            m  = (t == 1) ? 8'h00 : (t == 2) ? 8'hFF : 8'($urandom);
            for (int i = 0; i < 8; i++) begin
                waits[i] = $urandom_range(0, 3);
                rf[i]    = 16'($urandom);
            end
            run($sformatf("rnd%0d", t), sv, 0, b, m, -1, -1, -1);
            verify($sformatf("rnd%0d", t), sv, b, m);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
